// File: rtl/paridade_pkg.sv
// Shared definitions for the parity-checking round-robin arbiter.
// Holds the word widths and the controller state encoding.
package paridade_pkg;

  localparam int PAR_W  = 9;
  localparam int DADO_W = 8;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    VERIFICA = 2'd1,
    ENTREGA  = 2'd2
  } estado_t;

endpackage

// File: rtl/calcula_paridade.sv
// Even-parity generator for one data byte.
// This is the single checker shared by all requesters.
module calcula_paridade
  import paridade_pkg::*;
(
  input  logic [DADO_W-1:0] dado,
  output logic              paridade
);

  assign paridade = ^dado;

endmodule

// File: rtl/arbitro_paridade.sv
// Round-robin arbiter that grants one requester at a time to a shared parity checker.
// Each result is returned over a valid/ready port, with error statistics kept alongside.
module arbitro_paridade
  import paridade_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [PAR_W*N_REQ-1:0] req_dado,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_W-1:0]        res_id,
  output logic [DADO_W-1:0]      res_dado,
  output logic                   res_erro,
  output logic [CNT_W-1:0]       err_count,
  output logic [N_REQ-1:0]       err_mask,
  input  logic                   clr_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  estado_t           estado, estado_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   grant_id;
  logic              grant_found;
  logic              aceita;
  logic [ID_W-1:0]   cap_id;
  logic [PAR_W-1:0]  cap_word;
  logic              paridade_calc;
  logic              erro;
  logic [CNT_W-1:0]  cnt_base;
  logic [N_REQ-1:0]  mask_base;

  // Requester index `off` positions after `base`, wrapping at N_REQ.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
    return ID_W'((32'(base) + 32'(off)) % N_REQ);
  endfunction

  function automatic logic [N_REQ-1:0] one_hot(input logic [ID_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

  // Scan from the farthest index back to ptr so the nearest valid requester wins.
  always_comb begin
    // NOTE: every variable written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_idx(ptr, k)]) begin
        grant_found = 1'b1;
        grant_id    = rr_idx(ptr, k);
      end
    end
  end

  always_comb begin
    estado_nxt = estado;
    req_ready  = '0;
    unique case (estado)
      OCIOSO: begin
        if (grant_found) begin
          req_ready  = one_hot(grant_id);
          estado_nxt = VERIFICA;
        end
      end
      VERIFICA: estado_nxt = ENTREGA;
      ENTREGA:  if (res_ready) estado_nxt = OCIOSO;
      default:  estado_nxt = OCIOSO;
    endcase
    if (rst) req_ready = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) estado <= OCIOSO;
    else     estado <= estado_nxt;
  end

  assign aceita    = (estado == OCIOSO) && grant_found;
  assign res_valid = (estado == ENTREGA);

  calcula_paridade u_paridade (
    .dado     (cap_word[DADO_W-1:0]),
    .paridade (paridade_calc)
  );

  assign erro = paridade_calc ^ cap_word[PAR_W-1];

  // A clear coinciding with a new error is applied first, then the error on top.
  assign cnt_base  = clr_err ? '0 : err_count;
  assign mask_base = clr_err ? '0 : err_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      cap_id    <= '0;
      cap_word  <= '0;
      res_id    <= '0;
      res_dado  <= '0;
      res_erro  <= 1'b0;
      err_count <= '0;
      err_mask  <= '0;
    end else begin
      if (aceita) begin
        cap_word <= req_dado[32'(grant_id) * PAR_W +: PAR_W];
        cap_id   <= grant_id;
        ptr      <= rr_idx(grant_id, 1);
      end
      if (estado == VERIFICA) begin
        res_dado <= cap_word[DADO_W-1:0];
        res_id   <= cap_id;
        res_erro <= erro;
      end
      if ((estado == VERIFICA) && erro) begin
        err_count <= (cnt_base == CNT_MAX) ? cnt_base : cnt_base + CNT_W'(1);
        err_mask  <= mask_base | one_hot(cap_id);
      end else if (clr_err) begin
        err_count <= '0;
        err_mask  <= '0;
      end
    end
  end

endmodule

// File: doc/arbitro_paridade.md
# arbitro_paridade

Round-robin arbiter that shares a single `calcula_paridade` checker among `N_REQ` requesters. Each requester offers a 9-bit word: 8 data bits plus an even-parity bit in bit 8. The block grants one requester at a time and checks its word. It returns the data, the requester index and an error flag over a valid/ready result port. It also keeps a saturating error counter and per-requester sticky error flags. It sits between the receive front-ends and the consumer that logs or discards corrupted bytes.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, ≥2.
- `CNT_W`, 8: width of the error counter.
- `ID_W`, $clog2(N_REQ): width of the requester index.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; one clock, asynchronous and active-high.
- `req_valid`  in  N_REQ  requester i has a word pending.
- `req_dado`  in  9*N_REQ  word of requester i, at `[9i+8:9i]`. Bit 8 of each slice is the parity bit.
- `req_ready`  out  N_REQ  one-hot grant; the word is accepted when `req_valid[i] & req_ready[i]`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_id`  out  ID_W  index of the requester that produced the result.
- `res_dado`  out  8  data bits of the checked word.
- `res_erro`  out  1  1 when the received parity ≠ XOR of `dado[7:0]`.
- `err_count`  out  CNT_W  count of words with errors; saturates at 2^CNT_W−1.
- `err_mask`  out  N_REQ  sticky per-requester error flags.
- `clr_err`  in  1  synchronous clear of `err_count` and `err_mask`.

## Operation
The FSM has three states: OCIOSO, VERIFICA and ENTREGA.

- **OCIOSO**
  - Arbitration is round-robin. Scan `req_valid` starting at pointer `ptr`, i.e. indices ptr, ptr+1, …, wrapping mod N_REQ. The first set index is the grant g.
  - `req_ready` = one-hot(g), combinationally, only while in OCIOSO and `rst`=0. Otherwise `req_ready` = 0.
  - On the accept edge: capture the word and g, set `ptr` ← (g+1) mod N_REQ, go to VERIFICA.
  - If no `req_valid` is set, stay in OCIOSO and leave `ptr` unchanged.
- **VERIFICA** (exactly one cycle)
  - The captured `dado[7:0]` drives the `calcula_paridade` instance. `erro` = computed parity ≠ captured bit 8.
  - Register `res_dado`, `res_id` and `res_erro`.
  - If `erro` is set: `err_count` increments, saturating at its maximum, and `err_mask[g]` ← 1.
  - Go to ENTREGA.
- **ENTREGA**
  - `res_valid` = 1. All `res_*` outputs are held stable until `res_ready` = 1.
  - On the handshake edge, go to OCIOSO.
  - `res_valid` never drops without a handshake.
- **`clr_err` priority**
  - `clr_err` clears `err_count` and `err_mask` in any state.
  - If it coincides with an error update in VERIFICA: `err_count` ← 1 and `err_mask` ← one-hot(g). The clear applies first, then the new error.
- **Requester side**
  - Changes of `req_valid` or `req_dado` outside the accept cycle have no effect.
  - A requester must hold its word until it is granted.

## Timing
- Reset values: state OCIOSO, `ptr` 0, `req_ready` 0, `res_valid` 0, `res_id` 0, `res_dado` 0, `res_erro` 0, `err_count` 0, `err_mask` 0.
- Latency: accept at edge T, `res_valid` = 1 from edge T+2.
- Minimum period between accepts is 3 cycles, reached when `res_ready` is held at 1.
- Backpressure: every cycle that `res_ready` = 0 in ENTREGA adds one cycle. No requester is granted during that time.
- Fairness: with all requesters continuously valid, grants cycle 0, 1, …, N_REQ−1, 0.
- Reset asserted in any state, including mid-VERIFICA or mid-ENTREGA:
  - all registers return to their reset values immediately;
  - the in-flight word is discarded and no result is delivered;
  - the counter is not updated.
- Saturation: at 2^CNT_W−1, further errors leave `err_count` unchanged; `err_mask` still updates.

## Structure
- Shared package `paridade_pkg`:
  - state encoding (OCIOSO, VERIFICA, ENTREGA);
  - `PAR_W` = 9;
  - `DADO_W` = 8.
- One sub-module: the existing `calcula_paridade`, instantiated once as the shared resource.
- The round-robin search stays inline in this module.

## Test plan
- Single requester 0 sends 9'h0_A5 (even parity correct) with `res_ready` = 1:
  - grant at T, `res_valid` at T+2;
  - result `res_id` 0, `res_dado` 8'hA5, `res_erro` 0;
  - `err_count` stays 0.
- Requester 2 sends 9'h1_A5 (wrong parity):
  - result `res_erro` 1;
  - `err_count` = 1, `err_mask` = 4'b0100.
- All four requesters continuously valid for 8 words:
  - grant order 0, 1, 2, 3, 0, 1, 2, 3;
  - one accept every 3 cycles.
- Hold `res_ready` = 0 for 5 cycles in ENTREGA:
  - `res_*` outputs stay stable throughout;
  - `req_ready` = 0 throughout;
  - next accept follows the handshake edge by one cycle.
- Error counter and clear:
  - CNT_W = 2, send 5 bad words: `err_count` stops at 3;
  - assert `clr_err` in the VERIFICA cycle of a bad word from requester 1: `err_count` = 1, `err_mask` = 4'b0010.
- Reset during ENTREGA:
  - `res_valid` drops without waiting for a clock edge;
  - `ptr` = 0, so a subsequent request from all four requesters is granted to requester 0.
